fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It owns the PC and runs a valid/ready handshake with instruction memory. It presents instrF, pc_plus4F and validF to the IF/ID pipeline register, which it feeds directly. It honours stalls from the hazard unit and PC redirects from branch/jump resolution, including redirects that arrive while a memory request is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
NOP_INSTR, 32'h0000_0000, value driven on instrF whenever validF=0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
stallF  in  1  hazard unit: IF/ID holds this cycle, so the presented instruction is not consumed.
redirect  in  1  branch/jump taken; the instruction currently presented or fetching is wrong-path.
redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0 internally.
imem_req  out  1  memory request valid.
imem_addr  out  32  word-aligned fetch address.
imem_ready  in  1  memory returns imem_rdata this cycle; completes the request.
imem_rdata  in  32  instruction word.
instrF  out  32  presented instruction, or NOP_INSTR when validF=0.
pc_plus4F  out  32  PC of presented instruction + 4; 0 when validF=0.
pcF  out  32  current PC register (debug/visibility).
validF  out  1  instrF/pc_plus4F hold a real instruction.

Behaviour:
- State machine states: IDLE, REQ, VALID.
- Internal registers: pc, ibuf, pend_v, pend_pc.
- Reset (async, rst=0): state=IDLE, pc=RESET_PC, ibuf=0, pend_v=0. Outputs: imem_req=0, validF=0, instrF=NOP_INSTR, pc_plus4F=0, pcF=RESET_PC.
- IDLE: imem_req=0. Next edge goes to REQ. If redirect=1, pc<=redirect_pc first.
- REQ:
  - imem_req=1, imem_addr=pc. req and addr stay stable until imem_ready=1. No retraction.
  - imem_ready=1, pend_v=0, redirect=0: ibuf<=imem_rdata; go to VALID.
  - imem_ready=1 with pend_v=1 or redirect=1: data is discarded. pc<=(redirect ? redirect_pc : pend_pc); pend_v<=0; stay in REQ.
  - imem_ready=0, redirect=1: pend_v<=1, pend_pc<=redirect_pc. The newest redirect overwrites any earlier one. imem_addr is unchanged.
  - stallF is ignored in REQ.
- VALID:
  - validF=1, instrF=ibuf, pc_plus4F=pc+4.
  - redirect=1 has priority over stallF: pc<=redirect_pc, go to REQ, imem_req=0 this cycle.
  - stallF=1, no redirect: hold everything; imem_req=0.
  - stallF=0, no redirect: the instruction is consumed at this edge. Combinationally imem_req=1, imem_addr=pc+4, and pc<=pc+4.
    - imem_ready=1: ibuf<=imem_rdata; stay in VALID. Throughput is 1 instruction/cycle with zero-wait memory.
    - imem_ready=0: go to REQ; addr pc+4 stays stable there.
- Latency: reset release -> first imem_req is 1 cycle. With zero-wait memory, first validF=1 is 2 cycles after reset release.
- PC arithmetic: 32-bit, modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Reset asserted mid-request: immediate return to reset values. The outstanding response is not tracked; memory must drop it on reset.
- imem_req depends combinationally on state, stallF, redirect; imem_addr on state and pc. No combinational path from imem_ready to imem_req.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, REQ, VALID}, 2 bits.
  - PC_INC = 32'd4.
  - Default NOP_INSTR encoding (sll $0,$0,0 = 0).
- No sub-module required. Optional: a small fetch_next_pc function/block for the pc+4 / redirect mux.

Test Plan:
- Reset, imem_ready tied 1, rdata=addr|0xA0000000 -> imem_addr 0x0,0x4,0x8,... on consecutive cycles; validF=1 from 2nd cycle; pc_plus4F=addr+4.
- Memory with 3 wait states at 0x0 -> imem_req=1 and imem_addr=0x0 held 3 cycles, validF=0; 4th cycle ready -> next cycle validF=1, instrF=rdata, pc_plus4F=0x4.
- In VALID, stallF=1 for 2 cycles -> instrF, pc_plus4F, pcF constant, imem_req=0; stallF=0 -> imem_addr=pc+4 the same cycle.
- In VALID at pc=0x8, redirect=1, redirect_pc=0x103 -> next cycle validF=0, imem_addr=0x100; no fetch of 0xC observed.
- REQ at 0x8 with wait states; redirect to 0x200, then next cycle to 0x300 -> addr holds 0x8 until ready; that data is discarded (validF stays 0); next request addr=0x300.
- rst driven low mid-REQ at 0x40 -> same cycle imem_req=0, validF=0, instrF=0, pcF=RESET_PC; after release, first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory valid/ready request bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches from imem, feeds IF/ID; handles stalls and redirects,
// including redirects that land while a memory request is still outstanding.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallF,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          instrF,
  output logic [31:0]          pc_plus4F,
  output logic [31:0]          pcF,
  output logic                 validF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  redir_pc;
  logic [31:0]  pc_inc;

  assign redir_pc = word_align(redirect_pc);
  assign pc_inc   = pc_q + PC_INC;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ibuf_d         = ibuf_q;
    pend_v_d       = pend_v_q;
    pend_pc_d      = pend_pc_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redir_pc;
      end

      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          // A redirect seen during or at the end of the request makes this data wrong-path.
          if (pend_v_q || redirect) begin
            pc_d     = redirect ? redir_pc : pend_pc_q;
            pend_v_d = 1'b0;
          end else begin
            ibuf_d  = imem.imem_rdata;
            state_d = VALID;
          end
        end else if (redirect) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redir_pc;
        end
      end

      VALID: begin
        imem.imem_addr = pc_inc;
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (!stallF) begin
          imem.imem_req = 1'b1;
          pc_d          = pc_inc;
          if (imem.imem_ready) ibuf_d = imem.imem_rdata;
          else                 state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ibuf_q    <= '0;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ibuf_q    <= ibuf_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign validF    = (state_q == VALID);
  assign instrF    = validF ? ibuf_q : NOP_INSTR;
  assign pc_plus4F = validF ? pc_inc : '0;
  assign pcF       = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem model with switchable wait states, in-order scoreboard
// of consumed instructions plus direct checks of the request bus.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrF;
  logic [31:0] pc_plus4F;
  logic [31:0] pcF;
  logic        validF;
  logic        mem_ready_en;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem       (bus),
    .instrF     (instrF),
    .pc_plus4F  (pc_plus4F),
    .pcF        (pcF),
    .validF     (validF)
  );

  // Memory: returns address tagged with 0xA in the top nibble; ready only while requested.
  assign bus.imem_ready = mem_ready_en & bus.imem_req;
  assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard when the presented instruction is consumed at the coming edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (rst && validF && !stallF && !redirect) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_instrF", instrF, e.instr);
        chk("sb_pc_plus4F", pc_plus4F, e.pc4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    stallF       = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    mem_ready_en = 1'b1;

    // Reset values
    cycle();
    cycle();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_validF", 32'(validF), 32'd0);
    chk("rst_instrF", instrF, 32'h0);
    chk("rst_pc_plus4F", pc_plus4F, 32'h0);
    chk("rst_pcF", pcF, 32'h0);

    // Zero-wait streaming
    rst = 1'b1;
    #1;
    cycle();
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("first_validF", 32'(validF), 32'd0);
    for (int i = 0; i < 6; i++) sb.push_back('{32'hA000_0000 | 32'(4 * i), 32'(4 * i + 4)});
    cycle();
    for (int i = 0; i < 6; i++) begin
      chk("stream_validF", 32'(validF), 32'd1);
      chk("stream_addr", bus.imem_addr, 32'(4 * (i + 1)));
      chk("stream_pcF", pcF, 32'(4 * i));
      cycle();
    end

    // Stall holds presentation and suppresses requests
    stallF = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      chk("stall_instrF", instrF, 32'hA000_0018);
      chk("stall_pc_plus4F", pc_plus4F, 32'd28);
      chk("stall_pcF", pcF, 32'd24);
      if (k < 2) cycle();
    end
    stallF = 1'b0;
    #1;
    chk("unstall_req", 32'(bus.imem_req), 32'd1);
    chk("unstall_addr", bus.imem_addr, 32'd28);
    sb.push_back('{32'hA000_0018, 32'd28});
    cycle();

    // Redirect from VALID, misaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("redir_valid_req", 32'(bus.imem_req), 32'd0);
    cycle();
    redirect = 1'b0;
    #1;
    chk("redir_validF", 32'(validF), 32'd0);
    chk("redir_req", 32'(bus.imem_req), 32'd1);
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_pcF", pcF, 32'h100);
    sb.push_back('{32'hA000_0100, 32'h104});
    cycle();
    chk("redir_instrF", instrF, 32'hA000_0100);

    // Redirects during an outstanding request
    mem_ready_en = 1'b0;
    #1;
    chk("ws_req", 32'(bus.imem_req), 32'd1);
    chk("ws_addr", bus.imem_addr, 32'h104);
    cycle();
    chk("ws_validF", 32'(validF), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("pend1_addr", bus.imem_addr, 32'h104);
    cycle();
    redirect_pc = 32'h300;
    #1;
    chk("pend2_addr", bus.imem_addr, 32'h104);
    cycle();
    redirect = 1'b0;
    #1;
    chk("pend_hold_addr", bus.imem_addr, 32'h104);
    chk("pend_hold_validF", 32'(validF), 32'd0);
    cycle();
    chk("pend_hold2_req", 32'(bus.imem_req), 32'd1);
    chk("pend_hold2_addr", bus.imem_addr, 32'h104);
    mem_ready_en = 1'b1;
    #1;
    chk("discard_validF", 32'(validF), 32'd0);
    cycle();
    chk("after_discard_validF", 32'(validF), 32'd0);
    chk("after_discard_addr", bus.imem_addr, 32'h300);
    chk("after_discard_pcF", pcF, 32'h300);
    cycle();
    chk("pend_tgt_validF", 32'(validF), 32'd1);
    chk("pend_tgt_instrF", instrF, 32'hA000_0300);
    chk("pend_tgt_pc_plus4F", pc_plus4F, 32'h304);

    // PC wraparound at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    #1;
    chk("wrap_redir_req", 32'(bus.imem_req), 32'd0);
    cycle();
    redirect = 1'b0;
    #1;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    sb.push_back('{32'hFFFF_FFFC, 32'h0});
    cycle();
    chk("wrap_pc_plus4F", pc_plus4F, 32'h0);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);
    chk("wrap_instrF", instrF, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pcF", pcF, 32'h0);
    chk("wrap_next_instrF", instrF, 32'hA000_0000);
    chk("wrap_next_pc_plus4F", pc_plus4F, 32'h4);

    // Reset asserted while a request at 0x40 is outstanding
    redirect     = 1'b1;
    redirect_pc  = 32'h40;
    mem_ready_en = 1'b0;
    #1;
    cycle();
    redirect = 1'b0;
    #1;
    chk("midreq_req", 32'(bus.imem_req), 32'd1);
    chk("midreq_addr", bus.imem_addr, 32'h40);
    chk("midreq_pcF", pcF, 32'h40);
    rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.imem_req), 32'd0);
    chk("async_rst_validF", 32'(validF), 32'd0);
    chk("async_rst_instrF", instrF, 32'h0);
    chk("async_rst_pc_plus4F", pc_plus4F, 32'h0);
    chk("async_rst_pcF", pcF, 32'h0);
    cycle();
    cycle();
    rst = 1'b1;
    #1;

    // Three wait states at RESET_PC, ready on the fourth cycle
    cycle();
    for (int w = 0; w < 3; w++) begin
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", bus.imem_addr, 32'h0);
      chk("wait_validF", 32'(validF), 32'd0);
      cycle();
    end
    mem_ready_en = 1'b1;
    #1;
    chk("ready_addr", bus.imem_addr, 32'h0);
    chk("ready_validF", 32'(validF), 32'd0);
    sb.push_back('{32'hA000_0000, 32'h4});
    cycle();
    chk("ws_done_validF", 32'(validF), 32'd1);
    chk("ws_done_instrF", instrF, 32'hA000_0000);
    chk("ws_done_pc_plus4F", pc_plus4F, 32'h4);
    cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
